// File: rtl/sopc_pio_pulse.sv
// sopc_pio_pulse
// --------------
// Avalon-MM parallel output port with a hardware pulse-train engine.
// Software can write, set or clear the output bits. It can also ask for N
// clock pulses of programmable period on bit PULSE_BIT without bit-banging.
// The block is a zero-wait-state slave with combinational read data.
//
// Optional feature macro: SOPC_PIO_PULSE_IRQ_EN
//   When defined, the irq port and the IRQ register at word 5 exist.
//   The interrupt is pending at the end of every pulse train.
//
// Ports:
//   clk        in   1      system clock
//   reset_n    in   1      asynchronous active-low reset
//   address    in   3      word address
//   chipselect in   1      slave select
//   write_n    in   1      active-low write strobe
//   writedata  in   32     write data
//   readdata   out  32     combinational read data, latency 0
//   out_port   out  WIDTH  registered output port
//   busy       out  1      a pulse train is in progress
//   irq        out  1      level-high interrupt (macro builds only)
//
// Register map:
//   0 DATA  (R/W)   1 SET (W)   2 CLEAR (W)   3 DIV (R/W)
//   4 PULSE (R/W) : read = {busy, zeros, remaining}
//   5 IRQ   (R/W) : {pending, enable}; reserved when the feature is disabled
//   6, 7 reserved
module sopc_pio_pulse #(
    parameter int              WIDTH       = 8,
    parameter int              DIV_WIDTH   = 8,
    parameter int              CNT_WIDTH   = 16,
    parameter int              PULSE_BIT   = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             busy
`ifdef SOPC_PIO_PULSE_IRQ_EN
    ,
    output logic             irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1'b1);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    state_t               state_r, state_next_s;
    logic [WIDTH-1:0]     data_r, data_next_s;
    logic [DIV_WIDTH-1:0] div_r, div_next_s;
    logic [DIV_WIDTH-1:0] phase_r, phase_next_s;
    logic [CNT_WIDTH-1:0] remaining_r, remaining_next_s;
    logic [WIDTH-1:0]     out_port_r, out_next_s;
    logic                 busy_r;
    logic                 wr_s;
    logic                 idle_s;
    logic                 pulse_start_s;
    logic [31:0]          readdata_s;
    logic                 unused_s;

    // Only the low bits of writedata are used by each register.
    assign unused_s = ^writedata;

    assign wr_s          = chipselect & ~write_n;
    assign idle_s        = (state_r == ST_IDLE);
    assign pulse_start_s = wr_s && (address == 3'd4) && idle_s &&
                           (writedata[CNT_WIDTH-1:0] != CNT_ZERO);

    // Next value of the data register: DATA, SET and CLEAR writes.
    // These writes are accepted even during a train.
    always_comb begin
        data_next_s = data_r;
        if (wr_s) begin
            case (address)
                3'd0:    data_next_s = writedata[WIDTH-1:0];
                3'd1:    data_next_s = data_r | writedata[WIDTH-1:0];
                3'd2:    data_next_s = data_r & ~writedata[WIDTH-1:0];
                default: data_next_s = data_r;
            endcase
        end else begin
            data_next_s = data_r;
        end
    end

    // Next divider value. It is frozen while a train runs, so each phase of
    // a train has a constant length.
    always_comb begin
        div_next_s = div_r;
        if (wr_s && (address == 3'd3) && idle_s) begin
            div_next_s = writedata[DIV_WIDTH-1:0];
        end else begin
            div_next_s = div_r;
        end
    end

    // Pulse engine next state. The phase counter counts down from div to 0,
    // so every phase lasts div+1 cycles. remaining drops as each HIGH phase ends.
    always_comb begin
        state_next_s     = state_r;
        phase_next_s     = phase_r;
        remaining_next_s = remaining_r;
        case (state_r)
            ST_IDLE: begin
                if (pulse_start_s) begin
                    state_next_s     = ST_LOW;
                    phase_next_s     = div_r;
                    remaining_next_s = writedata[CNT_WIDTH-1:0];
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (phase_r == DIV_ZERO) begin
                    state_next_s = ST_HIGH;
                    phase_next_s = div_r;
                end else begin
                    phase_next_s = phase_r - DIV_ONE;
                end
            end
            ST_HIGH: begin
                if (phase_r == DIV_ZERO) begin
                    remaining_next_s = remaining_r - CNT_ONE;
                    phase_next_s     = div_r;
                    if (remaining_r == CNT_ONE) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_LOW;
                    end
                end else begin
                    phase_next_s = phase_r - DIV_ONE;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                phase_next_s     = DIV_ZERO;
                remaining_next_s = CNT_ZERO;
            end
        endcase
    end

    // Next output port value. The engine owns the pulse bit only while it runs.
    // The pin falls back to data in the same cycle that busy drops.
    always_comb begin
        out_next_s = data_next_s;
        if (state_next_s == ST_HIGH) begin
            out_next_s[PULSE_BIT] = 1'b1;
        end else if (state_next_s == ST_LOW) begin
            out_next_s[PULSE_BIT] = 1'b0;
        end else begin
            out_next_s[PULSE_BIT] = data_next_s[PULSE_BIT];
        end
    end

    // Register file, engine state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            data_r      <= RESET_VALUE;
            div_r       <= DIV_ZERO;
            phase_r     <= DIV_ZERO;
            remaining_r <= CNT_ZERO;
            out_port_r  <= RESET_VALUE;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            data_r      <= data_next_s;
            div_r       <= div_next_s;
            phase_r     <= phase_next_s;
            remaining_r <= remaining_next_s;
            out_port_r  <= out_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

`ifdef SOPC_PIO_PULSE_IRQ_EN
    logic irq_en_r, irq_en_next_s;
    logic irq_pend_r, irq_pend_next_s;
    logic irq_r;

    // IRQ register next state. A train ending in the same cycle as a clear
    // leaves the interrupt pending.
    always_comb begin
        irq_en_next_s   = irq_en_r;
        irq_pend_next_s = irq_pend_r;
        if (wr_s && (address == 3'd5)) begin
            irq_en_next_s = writedata[0];
            if (writedata[1]) begin
                irq_pend_next_s = 1'b0;
            end else begin
                irq_pend_next_s = irq_pend_r;
            end
        end else begin
            irq_en_next_s = irq_en_r;
        end
        if (busy_r && (state_next_s == ST_IDLE)) begin
            irq_pend_next_s = 1'b1;
        end else begin
            irq_pend_next_s = irq_pend_next_s;
        end
    end

    // IRQ state and registered interrupt output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_r   <= 1'b0;
            irq_pend_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            irq_en_r   <= irq_en_next_s;
            irq_pend_r <= irq_pend_next_s;
            irq_r      <= irq_en_next_s & irq_pend_next_s;
        end
    end

    assign irq = irq_r;
`endif

    // Combinational read mux. Write-only and reserved words read as zero.
    always_comb begin
        readdata_s = 32'h0000_0000;
        case (address)
            3'd0: readdata_s[WIDTH-1:0] = data_r;
            3'd3: readdata_s[DIV_WIDTH-1:0] = div_r;
            3'd4: begin
                readdata_s[CNT_WIDTH-1:0] = remaining_r;
                readdata_s[31]            = busy_r;
            end
`ifdef SOPC_PIO_PULSE_IRQ_EN
            3'd5: readdata_s[1:0] = {irq_pend_r, irq_en_r};
`endif
            default: readdata_s = 32'h0000_0000;
        endcase
    end

    assign readdata = readdata_s;
    assign out_port = out_port_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_sopc_pio_pulse.sv
// Randomised self-checking bench for sopc_pio_pulse. The reference model
// describes a pulse train by its start cycle, count and divider. The expected
// pin level, busy flag and remaining count are derived arithmetically from the
// number of cycles elapsed since the train started.
module tb_sopc_pio_pulse;

    localparam int         PB = 2;
    localparam logic [7:0] RV = 8'hA5;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        busy;
`ifdef SOPC_PIO_PULSE_IRQ_EN
    logic        irq;
`endif

    sopc_pio_pulse #(
        .WIDTH(8), .DIV_WIDTH(8), .CNT_WIDTH(16), .PULSE_BIT(PB), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .busy(busy)
`ifdef SOPC_PIO_PULSE_IRQ_EN
        , .irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    logic [7:0] m_data;
    logic [7:0] m_div;
    bit         t_act;
    int         t_start, t_n, t_div;
    int         cyc;
    bit         m_en, m_pend;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int elapsed();
        return cyc - t_start;
    endfunction

    function automatic bit m_busy();
        return t_act && (elapsed() < 2 * (t_div + 1) * t_n);
    endfunction

    function automatic logic [7:0] m_out();
        logic [7:0] o;
        o = m_data;
        if (m_busy()) o[PB] = ((elapsed() / (t_div + 1)) % 2) == 1;
        return o;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a)
            3'd0: r[7:0] = m_data;
            3'd3: r[7:0] = m_div;
            3'd4: if (m_busy()) begin
                r[31]   = 1'b1;
                r[15:0] = 16'(t_n - elapsed() / (2 * (t_div + 1)));
            end
`ifdef SOPC_PIO_PULSE_IRQ_EN
            3'd5: r[1:0] = {m_pend, m_en};
`endif
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_data = RV; m_div = 8'h00; t_act = 1'b0; m_en = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_edge(input bit wr, input logic [2:0] a, input logic [31:0] wd);
        bit was_busy;
        was_busy = m_busy();
        if (wr) begin
            case (a)
                3'd0: m_data = wd[7:0];
                3'd1: m_data = m_data | wd[7:0];
                3'd2: m_data = m_data & ~wd[7:0];
                3'd3: if (!was_busy) m_div = wd[7:0];
                3'd4: if (!was_busy && wd[15:0] != 16'h0) begin
                    t_act = 1'b1; t_n = int'(wd[15:0]); t_div = int'(m_div); t_start = cyc + 1;
                end
`ifdef SOPC_PIO_PULSE_IRQ_EN
                3'd5: begin
                    m_en = wd[0];
                    if (wd[1]) m_pend = 1'b0;
                end
`endif
                default: ;
            endcase
        end
        cyc++;
        if (was_busy && !m_busy()) m_pend = 1'b1;
    endtask

    task automatic check_outputs();
        check_eq("out_port", {24'h0, out_port}, {24'h0, m_out()});
        check_eq("busy", {31'h0, busy}, {31'h0, m_busy()});
`ifdef SOPC_PIO_PULSE_IRQ_EN
        check_eq("irq", {31'h0, irq}, {31'h0, m_en & m_pend});
`endif
    endtask

    // One bus cycle: optional write, then outputs and a random read are checked.
    task automatic do_cycle(input bit wr, input logic [2:0] a, input logic [31:0] wd);
        logic [2:0] ra;
        chipselect = wr; write_n = !wr; address = a; writedata = wd;
        @(posedge clk);
        model_edge(wr, a, wd);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        check_outputs();
        ra = 3'($urandom_range(0, 7));
        address = ra;
        #1;
        check_eq("readdata", readdata, m_read(ra));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 3'd0, 32'h0);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        check_outputs();
        address = 3'd0; #1 check_eq("rst_read0", readdata, 32'h0000_00A5);
        address = 3'd3; #1 check_eq("rst_read3", readdata, 32'h0);

        // DATA / SET / CLEAR
        do_cycle(1'b1, 3'd0, 32'h0000_000F);
        do_cycle(1'b1, 3'd1, 32'h0000_0030);
        do_cycle(1'b1, 3'd2, 32'h0000_0003);
        check_eq("data_3c", {24'h0, out_port}, 32'h0000_003C);

        // DIV=2, PULSE=3; ignored writes during the train; SET pulse bit
        do_cycle(1'b1, 3'd3, 32'h0000_0002);
        do_cycle(1'b1, 3'd4, 32'h0000_0003);
        do_cycle(1'b1, 3'd3, 32'h0000_0007);
        do_cycle(1'b1, 3'd4, 32'h0000_0005);
        do_cycle(1'b1, 3'd1, 32'h1 << PB);
        idle(20);
        address = 3'd3; #1 check_eq("div_kept", readdata, 32'h0000_0002);

        // zero-length request, then reset mid-train
        do_cycle(1'b1, 3'd4, 32'h0000_0000);
        idle(2);
        do_cycle(1'b1, 3'd3, 32'h0000_0001);
        do_cycle(1'b1, 3'd4, 32'h0000_0004);
        idle(5);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2 reset_n = 1'b1;

        // fastest train with interrupt enabled (addr 5 is reserved otherwise)
        do_cycle(1'b1, 3'd5, 32'h0000_0001);
        do_cycle(1'b1, 3'd3, 32'h0000_0000);
        do_cycle(1'b1, 3'd4, 32'h0000_0001);
        idle(3);
        do_cycle(1'b1, 3'd5, 32'h0000_0003);
        idle(2);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [2:0]  a;
                logic [31:0] wd;
                a  = 3'($urandom_range(0, 7));
                wd = $urandom;
                if (a == 3'd3) wd = (wd & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
                if (a == 3'd4) wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
                do_cycle(1'b1, a, wd);
            end else begin
                do_cycle(1'b0, 3'd0, 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
